// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared FSM state type and width helper for the register bus arbiter
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } bus_state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_picker.sv
// rtl/reg_bus_arbiter_picker.sv - combinational round-robin picker (first request at or after rr_ptr)
module rr_priority_picker
  import reg_bus_pkg::*;
#(
  parameter int NrOfRequesters = 4,
  parameter int IdxBits        = idx_width(NrOfRequesters)
) (
  input  logic [NrOfRequesters-1:0] req,
  input  logic [IdxBits-1:0]        rr_ptr,
  output logic                      any_req,
  output logic [IdxBits-1:0]        sel_idx
);

  logic [NrOfRequesters-1:0] rotated;
  logic [IdxBits-1:0]        offset;
  logic [IdxBits:0]          sum;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then map the offset back.
  always_comb begin
    rotated = NrOfRequesters'({req, req} >> rr_ptr);
    offset  = '0;
    for (int k = NrOfRequesters - 1; k >= 0; k--) begin
      if (rotated[k]) offset = IdxBits'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= (IdxBits+1)'(NrOfRequesters)) sum = sum - (IdxBits+1)'(NrOfRequesters);
    any_req = |req;
    sel_idx = sum[IdxBits-1:0];
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin arbiter and access sequencer for a shared-bus register bank
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int NrOfRequesters = 4,
  parameter int NrOfRegs       = 8,
  parameter int AddrBits       = 3,
  parameter int NrOfBits       = 32
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic                                Tick,
  input  logic [NrOfRequesters-1:0]           req,
  input  logic [NrOfRequesters-1:0]           we,
  input  logic [NrOfRequesters*AddrBits-1:0]  addr,
  input  logic [NrOfRequesters*NrOfBits-1:0]  wdata,
  input  logic [NrOfBits-1:0]                 rbus,
  output logic [NrOfRequesters-1:0]           grant,
  output logic [NrOfRequesters-1:0]           ack,
  output logic                                err,
  output logic [NrOfBits-1:0]                 rdata,
  output logic [NrOfRegs-1:0]                 reg_cs,
  output logic [NrOfRegs-1:0]                 reg_we,
  output logic [NrOfBits-1:0]                 reg_d,
  output logic                                busy
);

  localparam int IdxBits = idx_width(NrOfRequesters);
  localparam logic [AddrBits:0] RegLimit = (AddrBits+1)'(NrOfRegs);

  bus_state_t state, state_nxt;

  logic [IdxBits-1:0]        rr_ptr;
  logic [IdxBits-1:0]        owner;
  logic [IdxBits-1:0]        sel_idx;
  logic                      any_req;
  logic                      sel_we;
  logic [AddrBits-1:0]       sel_addr;
  logic [NrOfBits-1:0]       sel_wdata;
  logic                      lat_we;
  logic [AddrBits-1:0]       lat_addr;
  logic [NrOfBits-1:0]       lat_wdata;
  logic                      in_range;
  logic [NrOfRequesters-1:0] owner_onehot;
  logic [NrOfRegs-1:0]       addr_onehot;

  rr_priority_picker #(
    .NrOfRequesters(NrOfRequesters),
    .IdxBits       (IdxBits)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any_req(any_req),
    .sel_idx(sel_idx)
  );

  // Pull the selected master's request fields out of the packed buses.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NrOfRequesters; i++) begin
      if (sel_idx == IdxBits'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AddrBits +: AddrBits];
        sel_wdata = wdata[i*NrOfBits +: NrOfBits];
      end
    end
  end

  // One-hot decodes of the latched owner and address; out-of-range addresses decode to zero.
  always_comb begin
    for (int i = 0; i < NrOfRequesters; i++) owner_onehot[i] = (owner == IdxBits'(i));
    for (int r = 0; r < NrOfRegs; r++) addr_onehot[r] = (lat_addr == AddrBits'(r));
    in_range = ({1'b0, lat_addr} < RegLimit);
  end

  // State register; async reset drops state so reg_cs deasserts immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and outputs, decoded purely from registered state.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    ack       = '0;
    err       = 1'b0;
    reg_cs    = '0;
    reg_we    = '0;
    reg_d     = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (Tick && any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (Tick) state_nxt = ACK;
        grant  = owner_onehot;
        reg_cs = addr_onehot;
        if (lat_we) begin
          reg_we = addr_onehot;
          reg_d  = lat_wdata;
        end
      end
      ACK: begin
        if (Tick) state_nxt = IDLE;
        grant = owner_onehot;
        ack   = owner_onehot;
        err   = !in_range;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, read capture and round-robin pointer, all advancing only on Tick.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rr_ptr    <= '0;
      owner     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else if (Tick) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= sel_idx;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
          end
        end
        ACCESS: begin
          if (!lat_we) rdata <= in_range ? rbus : '0;
        end
        ACK: begin
          rr_ptr <= (owner == IdxBits'(NrOfRequesters - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench with transaction-level reference model
module tb_reg_bus_arbiter;

  localparam int NR   = 4;
  localparam int NREG = 6;
  localparam int AB   = 3;
  localparam int NB   = 32;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              Tick  = 1'b1;
  logic [NR-1:0]     req;
  logic [NR-1:0]     we;
  logic [NR*AB-1:0]  addr;
  logic [NR*NB-1:0]  wdata;
  logic [NB-1:0]     rbus;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     ack;
  logic              err;
  logic [NB-1:0]     rdata;
  logic [NREG-1:0]   reg_cs;
  logic [NREG-1:0]   reg_we;
  logic [NB-1:0]     reg_d;
  logic              busy;

  reg_bus_arbiter #(
    .NrOfRequesters(NR),
    .NrOfRegs      (NREG),
    .AddrBits      (AB),
    .NrOfBits      (NB)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rbus  (rbus),
    .grant (grant),
    .ack   (ack),
    .err   (err),
    .rdata (rdata),
    .reg_cs(reg_cs),
    .reg_we(reg_we),
    .reg_d (reg_d),
    .busy  (busy)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;
  bit check_en = 1'b0;
  bit tb_clr = 1'b1;
  int tick_mode = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
      end
    end
  endtask

  // Register bank the arbiter drives: rising-edge, clock-enabled by reg_we and Tick.
  logic [NB-1:0] bank [NREG];
  always @(posedge Clock) begin
    if (tb_clr) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else if (Tick) begin
      for (int i = 0; i < NREG; i++) if (reg_we[i]) bank[i] <= reg_d;
    end
  end

  always_comb begin
    rbus = 32'hBAD0_0BAD;
    for (int i = 0; i < NREG; i++) if (reg_cs[i]) rbus = bank[i];
  end

  // Tick pattern: always high, every third cycle, or random.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      cyc++;
      case (tick_mode)
        0:       Tick = 1'b1;
        1:       Tick = (cyc % 3 == 0);
        default: Tick = ($urandom % 5 != 0);
      endcase
    end
  end

  // Reference model: each accepted request occupies one access Tick then one ack Tick.
  function automatic int rr_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  int            m_phase;
  int            m_owner;
  int            m_ptr;
  bit            m_we;
  int            m_addr;
  logic [NB-1:0] m_wdata;
  logic [NB-1:0] m_rdata;
  logic [NB-1:0] mem [NREG];

  always @(posedge Clock or posedge Reset) begin
    if (tb_clr) for (int i = 0; i < NREG; i++) mem[i] <= '0;
    if (Reset) begin
      m_phase <= 0;
      m_ptr   <= 0;
      m_owner <= 0;
      m_rdata <= '0;
    end else if (Tick) begin
      if (m_phase == 0) begin
        if (rr_pick(req, m_ptr) >= 0) begin
          m_owner <= rr_pick(req, m_ptr);
          m_we    <= we[rr_pick(req, m_ptr)];
          m_addr  <= int'(addr[rr_pick(req, m_ptr)*AB +: AB]);
          m_wdata <= wdata[rr_pick(req, m_ptr)*NB +: NB];
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        if (m_addr < NREG) begin
          if (m_we) mem[m_addr] <= m_wdata;
          else      m_rdata <= mem[m_addr];
        end else if (!m_we) begin
          m_rdata <= '0;
        end
        m_phase <= 2;
      end else begin
        m_ptr   <= (m_owner + 1) % NR;
        m_phase <= 0;
      end
    end
  end

  logic [NR-1:0]   exp_grant, exp_ack;
  logic [NREG-1:0] exp_cs, exp_we;
  logic            exp_err;
  always_comb begin
    exp_grant = (m_phase != 0) ? (NR'(1) << m_owner) : '0;
    exp_ack   = (m_phase == 2) ? (NR'(1) << m_owner) : '0;
    exp_cs    = (m_phase == 1 && m_addr < NREG) ? (NREG'(1) << m_addr) : '0;
    exp_we    = m_we ? exp_cs : '0;
    exp_err   = (m_phase == 2) && (m_addr >= NREG);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (check_en) begin
      chk("busy",      64'(busy),   64'(m_phase != 0));
      chk("grant",     64'(grant),  64'(exp_grant));
      chk("ack",       64'(ack),    64'(exp_ack));
      chk("err",       64'(err),    64'(exp_err));
      chk("reg_cs",    64'(reg_cs), 64'(exp_cs));
      chk("reg_we",    64'(reg_we), 64'(exp_we));
      chk("rdata",     64'(rdata),  64'(m_rdata));
      chk("cs_onehot", 64'($countones(reg_cs) <= 1), 64'(1));
      if (m_phase == 1 && m_we) chk("reg_d", 64'(reg_d), 64'(m_wdata));
    end
  end

  task automatic access(input int m, input bit w, input int a, input logic [NB-1:0] d,
                        output logic [NB-1:0] rd, output bit e, output int lat, output int ack_cyc,
                        output logic [NREG-1:0] cs_or, output logic [NREG-1:0] we_or, output int cs_cyc);
    bit got;
    req[m] = 1'b1;
    we[m] = w;
    addr[m*AB +: AB] = AB'(a);
    wdata[m*NB +: NB] = d;
    got = 1'b0; lat = 0; ack_cyc = 0; cs_cyc = 0; cs_or = '0; we_or = '0;
    while (!got && lat < 60) begin
      @(negedge Clock);
      lat++;
      cs_or |= reg_cs;
      we_or |= reg_we;
      if (reg_cs != '0) cs_cyc++;
      got = ack[m];
    end
    chk("ack_arrived", 64'(got), 64'(1));
    rd = rdata;
    e = err;
    for (int c = 0; c < 20 && got; c++) begin
      ack_cyc++;
      if (Tick) break;
      @(negedge Clock);
      got = ack[m];
    end
    req[m] = 1'b0;
  endtask

  task automatic pulse_reset();
    req = '0;
    @(negedge Clock);
    #2 Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    #2 Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic new_req(input int i);
    req[i] = 1'b1;
    we[i] = 1'($urandom % 2);
    addr[i*AB +: AB] = AB'($urandom % 8);
    wdata[i*NB +: NB] = $urandom;
  endtask

  initial begin
    logic [NB-1:0]   rd;
    bit              e;
    int              lat, ack_cyc, cs_cyc;
    logic [NREG-1:0] cs_or, we_or;
    int              nacks;
    int              order [5];
    int              when [5];
    int              first, late_acks, late_grants, ack_seen;
    bit              drained;

    req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge Clock);
    chk("rst_busy",  64'(busy),   64'(0));
    chk("rst_grant", 64'(grant),  64'(0));
    chk("rst_ack",   64'(ack),    64'(0));
    chk("rst_cs",    64'(reg_cs), 64'(0));
    chk("rst_rdata", 64'(rdata),  64'(0));
    chk("rst_reg_d", 64'(reg_d),  64'(0));
    #2 Reset = 1'b0;
    tb_clr = 1'b0;
    check_en = 1'b1;
    @(negedge Clock);

    // Single write then read by master 1.
    access(1, 1'b1, 3, 32'hDEADBEEF, rd, e, lat, ack_cyc, cs_or, we_or, cs_cyc);
    chk("wr_latency", 64'(lat),    64'(2));
    chk("wr_cs",      64'(cs_or),  64'(6'h08));
    chk("wr_we",      64'(we_or),  64'(6'h08));
    chk("wr_cs_cyc",  64'(cs_cyc), 64'(1));
    chk("wr_ack_cyc", 64'(ack_cyc), 64'(1));
    chk("wr_err",     64'(e),      64'(0));
    access(1, 1'b0, 3, 32'h0, rd, e, lat, ack_cyc, cs_or, we_or, cs_cyc);
    chk("rd_data",    64'(rd),     64'(32'hDEADBEEF));
    chk("rd_err",     64'(e),      64'(0));
    chk("rd_we",      64'(we_or),  64'(0));

    // Round-robin with all four masters held from reset.
    pulse_reset();
    we = '0;
    addr = {3'd4, 3'd2, 3'd1, 3'd0};
    req = '1;
    nacks = 0;
    for (int c = 0; c < 40 && nacks < 5; c++) begin
      @(negedge Clock);
      if (ack != '0) begin
        order[nacks] = -1;
        for (int i = NR - 1; i >= 0; i--) if (ack[i]) order[nacks] = i;
        when[nacks] = c;
        nacks++;
      end
    end
    req = '0;
    chk("rr_count", 64'(nacks), 64'(5));
    for (int k = 0; k < nacks; k++) chk("rr_order", 64'(order[k]), 64'(k % 4));
    for (int k = 1; k < nacks; k++) chk("rr_spacing", 64'(when[k] - when[k-1]), 64'(3));
    repeat (3) @(negedge Clock);

    // Tick high every third cycle during a read.
    tick_mode = 1;
    repeat (4) @(negedge Clock);
    access(0, 1'b0, 3, 32'h0, rd, e, lat, ack_cyc, cs_or, we_or, cs_cyc);
    chk("tick_rdata",   64'(rd),      64'(32'hDEADBEEF));
    chk("tick_ack_cyc", 64'(ack_cyc), 64'(3));
    chk("tick_cs_cyc",  64'(cs_cyc),  64'(3));
    tick_mode = 0;
    repeat (4) @(negedge Clock);

    // Prime register 5, then out-of-range write and read by master 2.
    access(0, 1'b1, 5, 32'h5555AAAA, rd, e, lat, ack_cyc, cs_or, we_or, cs_cyc);
    access(2, 1'b1, 7, 32'hCAFEF00D, rd, e, lat, ack_cyc, cs_or, we_or, cs_cyc);
    chk("oor_wr_err", 64'(e),     64'(1));
    chk("oor_wr_cs",  64'(cs_or), 64'(0));
    chk("oor_wr_we",  64'(we_or), 64'(0));
    access(2, 1'b0, 7, 32'h0, rd, e, lat, ack_cyc, cs_or, we_or, cs_cyc);
    chk("oor_rd_err",   64'(e),     64'(1));
    chk("oor_rd_rdata", 64'(rd),    64'(0));
    chk("oor_rd_cs",    64'(cs_or), 64'(0));

    // Reset asserted mid-cycle during a write's ACCESS.
    req[0] = 1'b1; we[0] = 1'b1; addr[0 +: AB] = 3'd5; wdata[0 +: NB] = 32'h12345678;
    first = 0;
    for (int c = 0; c < 20 && !first; c++) begin
      @(negedge Clock);
      first = int'(grant[0]);
    end
    chk("rst_test_granted", 64'(first), 64'(1));
    #2 Reset = 1'b1;
    req[0] = 1'b0;
    #1;
    chk("rst_async_cs", 64'(reg_cs), 64'(0));
    chk("rst_async_we", 64'(reg_we), 64'(0));
    ack_seen = 0;
    repeat (2) begin
      @(negedge Clock);
      if (ack != '0) ack_seen++;
    end
    #2 Reset = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      if (ack != '0) ack_seen++;
    end
    chk("rst_no_ack", 64'(ack_seen), 64'(0));
    chk("rst_reg5",   64'(bank[5]),  64'(32'h5555AAAA));

    // Pointer back at 0: masters 1 and 3 together, master 1 must win.
    req[1] = 1'b1; we[1] = 1'b0; addr[1*AB +: AB] = 3'd0;
    req[3] = 1'b1; we[3] = 1'b0; addr[3*AB +: AB] = 3'd1;
    first = -1;
    for (int c = 0; c < 20 && first < 0; c++) begin
      @(negedge Clock);
      for (int i = NR - 1; i >= 0; i--) if (ack[i]) first = i;
    end
    req = '0;
    chk("ptr_after_reset", 64'(first), 64'(1));
    repeat (2) @(negedge Clock);

    // Late drop: master 0 requests only while master 3 owns the bus.
    req[3] = 1'b1; we[3] = 1'b0; addr[3*AB +: AB] = 3'd2;
    first = 0;
    for (int c = 0; c < 20 && !first; c++) begin
      @(negedge Clock);
      first = int'(grant[3]);
    end
    req[0] = 1'b1; we[0] = 1'b0; addr[0 +: AB] = 3'd4;
    late_acks = 0; late_grants = 0;
    @(negedge Clock);
    req[0] = 1'b0;
    for (int c = 0; c < 10 && !ack[3]; c++) @(negedge Clock);
    req[3] = 1'b0;
    repeat (8) begin
      @(negedge Clock);
      if (ack[0]) late_acks++;
      if (grant[0]) late_grants++;
    end
    chk("late_drop_ack",   64'(late_acks),   64'(0));
    chk("late_drop_grant", 64'(late_grants), 64'(0));

    // Randomised traffic with random Tick.
    tick_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clock);
      for (int i = 0; i < NR; i++) begin
        if (req[i] && ack[i]) begin
          if (Tick) begin
            if ($urandom % 3 == 0) new_req(i);
            else req[i] = 1'b0;
          end
        end else if (req[i] && !grant[i]) begin
          if ($urandom % 16 == 0) req[i] = 1'b0;
        end else if (!req[i] && ($urandom % 4 == 0)) begin
          new_req(i);
        end
      end
    end
    drained = 1'b0;
    for (int c = 0; c < 400 && !drained; c++) begin
      @(negedge Clock);
      for (int i = 0; i < NR; i++) if (req[i] && ack[i] && Tick) req[i] = 1'b0;
      if (req == '0 && !busy) drained = 1'b1;
    end
    chk("drain", 64'(drained), 64'(1));
    tick_mode = 0;
    repeat (4) @(negedge Clock);
    for (int i = 0; i < NREG; i++) chk("bank_vs_model", 64'(bank[i]), 64'(mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
